// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared constants for the seven-segment scan driver: SEG bus
//            width, maximum supported digit count and the hex-to-a..g
//            segment code table.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

  localparam int SEG_W      = 8;
  localparam int MAX_DIGITS = 8;

  // Bit 6 = segment a ... bit 0 = segment g.
  localparam logic [6:0] SEG_CODES [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79,   // 0 1 2 3
    7'h33, 7'h5B, 7'h5F, 7'h70,   // 4 5 6 7
    7'h7F, 7'h7B, 7'h77, 7'h1F,   // 8 9 A b
    7'h4E, 7'h3D, 7'h4F, 7'h47    // C d E F
  };

  function automatic logic [6:0] seg_lookup(input logic [3:0] sym);
    return SEG_CODES[sym];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg_decode
// Purpose  : Combinational hex symbol to a..g segment decoder.
// Ports    : i_sym      [3:0] hex symbol
//            o_abcdefg  [6:0] segments, bit 6 = a ... bit 0 = g
// Revision : 1.0 - initial release
// ============================================================================
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_sym,
  output logic [6:0] o_abcdefg
);

  always_comb begin
    o_abcdefg = seg_lookup(i_sym);
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Purpose  : Time-multiplexed seven-segment display driver. A prescaler
//            sets the dwell time per digit; display data is double
//            buffered so a frame never mixes old and new contents.
// Ports    : clk, rst          clock, synchronous active-high reset
//            en                scan enable (0 = display dark, scan frozen)
//            load              capture symbols/dps/blank
//            symbols [4N-1:0]  hex code per digit, digit i at [4i+3:4i]
//            dps     [N-1:0]   decimal point per digit
//            blank   [N-1:0]   1 = digit fully dark
//            SEG     [7:0]     [7:1] = a..g, [0] = dp (registered)
//            COM     [N-1:0]   one-hot digit select (registered)
//            busy              pending data not yet displayed
//            frame_done        one-cycle pulse as digit 0 of a new frame shows
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter bit SEG_INV    = 1'b0,
  parameter bit COM_INV    = 1'b0
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] symbols,
  input  logic [NUM_DIGITS-1:0]   dps,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [SEG_W-1:0]        SEG,
  output logic [NUM_DIGITS-1:0]   COM,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_pre_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_idx_w-1:0]    c_idx_last = c_idx_w'(NUM_DIGITS - 1);
  localparam logic [c_pre_w-1:0]    c_pre_last = c_pre_w'(SCAN_DIV - 1);
  localparam logic [SEG_W-1:0]      c_seg_off  = {SEG_W{SEG_INV}};
  localparam logic [NUM_DIGITS-1:0] c_com_off  = {NUM_DIGITS{COM_INV}};

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS || SCAN_DIV < 1) begin : g_bad_params
    $error("seg_scan_driver: NUM_DIGITS must be 1..%0d and SCAN_DIV >= 1", MAX_DIGITS);
  end

  logic [c_pre_w-1:0]      presc_q, presc_d;
  logic [c_idx_w-1:0]      idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_sym_q, pend_sym_d, act_sym_q, act_sym_d;
  logic [NUM_DIGITS-1:0]   pend_dps_q, pend_dps_d, act_dps_q, act_dps_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic                    busy_q, busy_d;
  logic                    wrap_q, wrap_d;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   com_q, com_d;
  logic                    fdone_q, fdone_d;

  logic                    w_tick;
  logic                    w_frame_bnd;
  logic [3:0]              w_cur_sym;
  logic                    w_cur_dp;
  logic                    w_cur_blank;
  logic [6:0]              w_cur_abcdefg;

  // Select the active data of the digit currently being scanned.
  always_comb begin
    w_cur_sym   = '0;
    w_cur_dp    = 1'b0;
    w_cur_blank = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == c_idx_w'(i)) begin
        w_cur_sym   = act_sym_q[4*i +: 4];
        w_cur_dp    = act_dps_q[i];
        w_cur_blank = act_blank_q[i];
      end
    end
  end

  seg_decode u_decode (
    .i_sym     (w_cur_sym),
    .o_abcdefg (w_cur_abcdefg)
  );

  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    pend_sym_d   = pend_sym_q;
    pend_dps_d   = pend_dps_q;
    pend_blank_d = pend_blank_q;
    act_sym_d    = act_sym_q;
    act_dps_d    = act_dps_q;
    act_blank_d  = act_blank_q;
    busy_d       = busy_q;
    seg_d        = c_seg_off;
    com_d        = c_com_off;
    fdone_d      = 1'b0;

    w_tick      = en && (presc_q == c_pre_last);
    w_frame_bnd = w_tick && (idx_q == c_idx_last);
    wrap_d      = w_frame_bnd;

    // Scan timing: prescaler and digit index freeze while disabled.
    if (en) begin
      if (w_tick) begin
        presc_d = '0;
        idx_d   = (idx_q == c_idx_last) ? '0 : idx_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    // Double buffering. A load landing on the frame boundary bypasses the
    // pending stage; otherwise pending is promoted at the boundary (or at
    // once when the scan is stopped, since no frame is in flight).
    if (load && w_frame_bnd) begin
      act_sym_d   = symbols;
      act_dps_d   = dps;
      act_blank_d = blank;
      busy_d      = 1'b0;
    end else begin
      if (busy_q && (w_frame_bnd || !en)) begin
        act_sym_d   = pend_sym_q;
        act_dps_d   = pend_dps_q;
        act_blank_d = pend_blank_q;
        busy_d      = 1'b0;
      end
      if (load) begin
        pend_sym_d   = symbols;
        pend_dps_d   = dps;
        pend_blank_d = blank;
        busy_d       = 1'b1;
      end
    end

    // Outputs are registered one clock behind index/data; frame_done uses
    // the delayed boundary flag so it lines up with COM showing digit 0.
    if (en) begin
      com_d   = (NUM_DIGITS'(1) << idx_q) ^ c_com_off;
      seg_d   = (w_cur_blank ? '0 : {w_cur_abcdefg, w_cur_dp}) ^ c_seg_off;
      fdone_d = wrap_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_sym_q   <= '0;
      pend_dps_q   <= '0;
      pend_blank_q <= '0;
      act_sym_q    <= '0;
      act_dps_q    <= '0;
      act_blank_q  <= '1;
      busy_q       <= 1'b0;
      wrap_q       <= 1'b0;
      seg_q        <= c_seg_off;
      com_q        <= c_com_off;
      fdone_q      <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_sym_q   <= pend_sym_d;
      pend_dps_q   <= pend_dps_d;
      pend_blank_q <= pend_blank_d;
      act_sym_q    <= act_sym_d;
      act_dps_q    <= act_dps_d;
      act_blank_q  <= act_blank_d;
      busy_q       <= busy_d;
      wrap_q       <= wrap_d;
      seg_q        <= seg_d;
      com_q        <= com_d;
      fdone_q      <= fdone_d;
    end
  end

  assign SEG        = seg_q;
  assign COM        = com_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Purpose  : Self-checking bench for seg_scan_driver. Two instances share
//            the stimulus: one with plain polarity, one with SEG and COM
//            inverted. A digit-level reference model predicts all outputs.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

  localparam int N   = 4;
  localparam int DIV = 3;

  logic         clk = 1'b0;
  logic         rst, en, load;
  logic [15:0]  symbols;
  logic [3:0]   dps, blank;
  logic [7:0]   seg_a, seg_b;
  logic [3:0]   com_a, com_b;
  logic         busy_a, busy_b, fd_a, fd_b;

  always #5 clk = ~clk;

  seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .SEG_INV(1'b0), .COM_INV(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .load(load), .symbols(symbols), .dps(dps), .blank(blank),
    .SEG(seg_a), .COM(com_a), .busy(busy_a), .frame_done(fd_a)
  );

  seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .SEG_INV(1'b1), .COM_INV(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .load(load), .symbols(symbols), .dps(dps), .blank(blank),
    .SEG(seg_b), .COM(com_b), .busy(busy_b), .frame_done(fd_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (digit-level view) ----------------
  logic [6:0] lut [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  int         m_cnt, m_dig;
  int         m_act_sym [N];
  int         m_pend_sym[N];
  bit         m_act_dp  [N], m_pend_dp  [N];
  bit         m_act_blk [N], m_pend_blk [N];
  bit         m_busy, m_wrap, m_fd;
  logic [7:0] m_seg;
  logic [3:0] m_com;

  task automatic model_reset();
    m_cnt = 0; m_dig = 0; m_busy = 0; m_wrap = 0; m_fd = 0;
    m_seg = 8'h00; m_com = 4'h0;
    for (int i = 0; i < N; i++) begin
      m_act_sym[i] = 0; m_pend_sym[i] = 0;
      m_act_dp[i]  = 0; m_pend_dp[i]  = 0;
      m_act_blk[i] = 1; m_pend_blk[i] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit boundary;
    if (rst) begin
      model_reset();
      return;
    end
    // Outputs show the digit/data that were current before this edge.
    if (en) begin
      m_com = 4'(1 << m_dig);
      m_seg = m_act_blk[m_dig] ? 8'h00 : {lut[m_act_sym[m_dig]], m_act_dp[m_dig]};
      m_fd  = m_wrap;
    end else begin
      m_com = 4'h0; m_seg = 8'h00; m_fd = 0;
    end
    boundary = en && (m_cnt == DIV - 1) && (m_dig == N - 1);
    m_wrap   = boundary;
    if (load && boundary) begin
      for (int i = 0; i < N; i++) begin
        m_act_sym[i] = int'(symbols[4*i +: 4]); m_act_dp[i] = dps[i]; m_act_blk[i] = blank[i];
      end
      m_busy = 0;
    end else begin
      if (m_busy && (boundary || !en)) begin
        for (int i = 0; i < N; i++) begin
          m_act_sym[i] = m_pend_sym[i]; m_act_dp[i] = m_pend_dp[i]; m_act_blk[i] = m_pend_blk[i];
        end
        m_busy = 0;
      end
      if (load) begin
        for (int i = 0; i < N; i++) begin
          m_pend_sym[i] = int'(symbols[4*i +: 4]); m_pend_dp[i] = dps[i]; m_pend_blk[i] = blank[i];
        end
        m_busy = 1;
      end
    end
    if (en) begin
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_dig = (m_dig + 1) % N;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  // One clock: edge, model update, then compare both instances 1 ns later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("seg",      seg_a,  m_seg);
    check("com",      com_a,  m_com);
    check("seg_inv",  seg_b,  m_seg ^ 8'hFF);
    check("com_inv",  com_b,  m_com ^ 4'hF);
    check("busy",     busy_a, m_busy);
    check("busy_inv", busy_b, m_busy);
    check("fdone",    fd_a,   m_fd);
    check("fdone_inv",fd_b,   m_fd);
  endtask

  // Run until the next edge will see the given digit/prescaler position.
  task automatic run_to(input int dig, input int cnt);
    int guard = 0;
    while (!(m_dig == dig && m_cnt == cnt) && guard < 100) begin
      step();
      guard++;
    end
    if (!(m_dig == dig && m_cnt == cnt)) begin
      n_checks++; n_fail++;
      $display("FAIL run_to: position %0d/%0d not reached in 100 cycles", dig, cnt);
    end
  endtask

  task automatic wait_fd();
    int guard = 0;
    do begin
      step();
      guard++;
    end while (fd_a !== 1'b1 && guard < 40);
    if (fd_a !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL wait_fd: no frame_done within 40 cycles");
    end
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; symbols = '0; dps = '0; blank = '0;
    model_reset();
    step(); step();
    check("rst_seg",     seg_a, 8'h00);
    check("rst_com",     com_a, 4'b0000);
    check("rst_seg_inv", seg_b, 8'hFF);
    check("rst_com_inv", com_b, 4'b1111);
    check("rst_busy",    busy_a, 1'b0);

    // Free-running scan with nothing loaded: blank display.
    rst = 1'b0; en = 1'b1;
    step();
    check("scan_first_com", com_a, 4'b0001);
    check("scan_first_seg", seg_a, 8'h00);
    step_n(23);

    // Mid-frame load: held until the frame boundary.
    run_to(1, 1);
    load = 1'b1; symbols = 16'h1A2F; dps = 4'b0100; blank = 4'b0000;
    step();
    load = 1'b0;
    check("load_busy", busy_a, 1'b1);
    wait_fd();
    check("frm_busy_clr", busy_a, 1'b0);
    check("frm_d0", seg_a, 8'h8E);    // F
    step_n(3);
    check("frm_d1", seg_a, 8'hDA);    // 2 -> 6D<<1
    step_n(3);
    check("frm_d2", seg_a, 8'hEF);    // A + dp
    step_n(3);
    check("frm_d3", seg_a, 8'h60);    // 1

    // Two loads in one frame: only the second is ever shown.
    run_to(0, 1);
    dps = 4'b0000; symbols = 16'h1111; load = 1'b1;
    step();
    load = 1'b0;
    run_to(2, 0);
    symbols = 16'h2222; load = 1'b1;
    step();
    load = 1'b0;
    check("dbl_busy", busy_a, 1'b1);
    wait_fd();
    for (int d = 0; d < N; d++) begin
      check("dbl_digit", seg_a, 8'hDA);
      step_n(3);
    end

    // Load exactly on the frame-boundary edge goes straight to active.
    run_to(3, 2);
    symbols = 16'h0007; dps = 4'b0001; load = 1'b1;
    step();
    load = 1'b0;
    check("bnd_busy", busy_a, 1'b0);
    step();
    check("bnd_seg", seg_a, 8'hE1);   // 7 + dp
    check("bnd_com", com_a, 4'b0001);
    check("bnd_fd",  fd_a,  1'b1);

    // Blanked digit on the inverted instance.
    run_to(1, 0);
    symbols = 16'h8888; dps = 4'b0000; blank = 4'b0010; load = 1'b1;
    step();
    load = 1'b0;
    wait_fd();
    check("inv_com_d0", com_b, 4'b1110);
    step_n(3);
    check("inv_blank_seg", seg_b, 8'hFF);
    check("blank_seg",     seg_a, 8'h00);
    blank = 4'b0000;

    // Disable mid-digit, resume at the held digit, then reset mid-frame.
    run_to(1, 1);
    en = 1'b0;
    step_n(5);
    check("dis_com", com_a, 4'b0000);
    check("dis_seg", seg_a, 8'h00);
    en = 1'b1;
    step();
    check("resume_com", com_a, 4'b0010);
    symbols = 16'h3456; load = 1'b1;
    step();
    load = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_busy", busy_a, 1'b0);
    check("mrst_com",  com_a, 4'b0000);
    step();
    check("post_rst_com", com_a, 4'b0001);
    check("post_rst_seg", seg_a, 8'h00);
    step_n(12);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      rst     = ($urandom_range(0, 99) == 0);
      en      = ($urandom_range(0, 7) != 0);
      load    = ($urandom_range(0, 5) == 0);
      symbols = 16'($urandom);
      dps     = 4'($urandom);
      blank   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
